// File: rtl/vga_pixel_pipeline_if.sv
// Signal bundle between the VGA timing controller / framebuffer side and the pixel pipeline.
// The pipeline takes the slave view and the surrounding system takes the master view.
interface vga_pixel_pipeline_if;
  logic [11:0] display_col;
  logic [10:0] display_row;
  logic        visible;
  logic        hsync_in;
  logic        vsync_in;
  logic        calc;
  logic [15:0] fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_data;
  logic        swap_req;
  logic        swap_ack;
  logic        front_buf;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  logic        hsync_out;
  logic        vsync_out;
  logic [15:0] frame_count;

  modport master (
    output display_col, display_row, visible, hsync_in, vsync_in, calc, fb_data, swap_req,
    input  fb_addr, fb_rd_en, swap_ack, front_buf, red, green, blue, hsync_out, vsync_out,
           frame_count
  );

  modport slave (
    input  display_col, display_row, visible, hsync_in, vsync_in, calc, fb_data, swap_req,
    output fb_addr, fb_rd_en, swap_ack, front_buf, red, green, blue, hsync_out, vsync_out,
           frame_count
  );
endinterface

// File: rtl/vga_pixel_pipeline.sv
// 800x600 scan of a 200x150 double-buffered RGB332 framebuffer at 4x scaling, with sync
// delay matching the 3-cycle pixel path and a vblank-only front-buffer swap handshake.
module vga_pixel_pipeline #(
  parameter int unsigned FB_W        = 200,
  parameter int unsigned FB_H        = 150,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input logic            clock,
  input logic            reset,
  vga_pixel_pipeline_if.slave bus
);

  // The address multiply is hard-built from shifts for a width of 200 and a 4x scale.
  if (FB_W != 200 || FB_H != 150 || SCALE_SHIFT != 2) begin : g_geom_check
    $error("vga_pixel_pipeline: geometry fixed at 200x150, scale 4");
  end

  logic [15:0] fb_addr_q;
  logic        rd_en_q;
  logic        rd_en_p2_q;
  logic [7:0]  rgb_q;
  logic [2:0]  hs_q;
  logic [2:0]  vs_q;
  logic        calc_dly_q;
  logic        swap_req_dly_q;
  logic        pending_q;
  logic        front_buf_q;
  logic        swap_ack_q;
  logic [15:0] frame_count_q;

  logic [9:0]  x;
  logic [8:0]  y;
  logic [14:0] y_ext;
  logic [14:0] lin_addr;
  logic        in_range;
  logic        calc_rise;
  logic        swap_rise;

  always_comb begin
    x         = bus.display_col[11:2];
    y         = bus.display_row[10:2];
    y_ext     = {6'd0, y};
    lin_addr  = (y_ext << 7) + (y_ext << 6) + (y_ext << 3) + {5'd0, x};
    in_range  = bus.visible && (bus.display_col < 12'd800) && (bus.display_row < 11'd600);
    calc_rise = bus.calc && !calc_dly_q;
    swap_rise = bus.swap_req && !swap_req_dly_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fb_addr_q      <= '0;
      rd_en_q        <= 1'b0;
      rd_en_p2_q     <= 1'b0;
      rgb_q          <= '0;
      hs_q           <= '1;
      vs_q           <= '1;
      calc_dly_q     <= 1'b0;
      swap_req_dly_q <= 1'b0;
      pending_q      <= 1'b0;
      front_buf_q    <= 1'b0;
      swap_ack_q     <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      rd_en_q <= in_range;
      if (in_range) begin
        fb_addr_q <= {front_buf_q, lin_addr};
      end
      rd_en_p2_q <= rd_en_q;
      rgb_q      <= rd_en_p2_q ? bus.fb_data : 8'd0;
      hs_q       <= {hs_q[1:0], bus.hsync_in};
      vs_q       <= {vs_q[1:0], bus.vsync_in};

      calc_dly_q     <= bus.calc;
      swap_req_dly_q <= bus.swap_req;

      // A request edge landing on the vblank edge itself swaps immediately.
      if (calc_rise && (pending_q || swap_rise)) begin
        front_buf_q <= !front_buf_q;
        swap_ack_q  <= 1'b1;
        pending_q   <= 1'b0;
      end else begin
        swap_ack_q <= 1'b0;
        if (swap_rise) begin
          pending_q <= 1'b1;
        end
      end

      if (calc_rise) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_rd_en    = rd_en_q;
  assign bus.red         = rgb_q[7:5];
  assign bus.green       = rgb_q[4:2];
  assign bus.blue        = rgb_q[1:0];
  assign bus.hsync_out   = hs_q[2];
  assign bus.vsync_out   = vs_q[2];
  assign bus.swap_ack    = swap_ack_q;
  assign bus.front_buf   = front_buf_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Directed bench for vga_pixel_pipeline: address map, pixel latency, blanking, syncs,
// swap handshake, reset abort and frame counter wrap.
module tb_vga_pixel_pipeline;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   ack_count;
  logic [7:0] ram_val = 8'hE3;

  vga_pixel_pipeline_if bus ();

  vga_pixel_pipeline #(.FB_W(200), .FB_H(150), .SCALE_SHIFT(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #10 clock = ~clock;

  // RAM model: one-cycle synchronous read.
  always @(posedge clock) begin
    if (bus.fb_rd_en) bus.fb_data <= ram_val;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, bus.red, bus.green, bus.blue}, {24'd0, exp});
  endtask

  task automatic drive(input int col, input int row, input logic vis);
    bus.display_col = 12'(col);
    bus.display_row = 11'(row);
    bus.visible     = vis;
  endtask

  initial begin
    bus.display_col = '0;
    bus.display_row = '0;
    bus.visible     = 1'b0;
    bus.hsync_in    = 1'b1;
    bus.vsync_in    = 1'b1;
    bus.calc        = 1'b0;
    bus.swap_req    = 1'b0;
    bus.fb_data     = '0;

    // Reset state
    tick(); tick();
    chk_rgb("rst_rgb", 8'h00);
    chk("rst_hs", {31'd0, bus.hsync_out}, 32'd1);
    chk("rst_vs", {31'd0, bus.vsync_out}, 32'd1);
    chk("rst_rden", {31'd0, bus.fb_rd_en}, 32'd0);
    chk("rst_addr", {16'd0, bus.fb_addr}, 32'd0);
    chk("rst_ack", {31'd0, bus.swap_ack}, 32'd0);
    chk("rst_fbuf", {31'd0, bus.front_buf}, 32'd0);
    chk("rst_fcnt", {16'd0, bus.frame_count}, 32'd0);
    reset = 1'b0;
    tick(); tick();

    // Address mapping and pixel latency
    drive(0, 0, 1'b1);
    tick();
    chk("addr_0_0", {16'd0, bus.fb_addr}, 32'd0);
    chk("rden_0_0", {31'd0, bus.fb_rd_en}, 32'd1);
    chk_rgb("rgb_n1", 8'h00);
    drive(7, 5, 1'b1);
    tick();
    chk("addr_7_5", {16'd0, bus.fb_addr}, 32'd201);
    chk("rden_7_5", {31'd0, bus.fb_rd_en}, 32'd1);
    chk_rgb("rgb_n2", 8'h00);
    drive(799, 599, 1'b1);
    tick();
    chk("addr_799_599", {16'd0, bus.fb_addr}, 32'd29999);
    chk("rden_799_599", {31'd0, bus.fb_rd_en}, 32'd1);
    chk("red_n3", {29'd0, bus.red}, 32'd7);
    chk("green_n3", {29'd0, bus.green}, 32'd0);
    chk("blue_n3", {30'd0, bus.blue}, 32'd3);

    // Out-of-range coordinates with visible stuck high: blank, address held
    drive(800, 0, 1'b1);
    tick();
    chk("rden_col800", {31'd0, bus.fb_rd_en}, 32'd0);
    chk("addr_hold_col800", {16'd0, bus.fb_addr}, 32'd29999);
    drive(0, 600, 1'b1);
    tick();
    chk("rden_row600", {31'd0, bus.fb_rd_en}, 32'd0);
    chk("addr_hold_row600", {16'd0, bus.fb_addr}, 32'd29999);
    drive(0, 0, 1'b0);
    tick();
    chk_rgb("rgb_col800_blank", 8'h00);
    tick();
    chk_rgb("rgb_row600_blank", 8'h00);
    tick(); tick();

    // Blanking with hsync low for 10 cycles; output delayed by 3
    for (int i = 0; i < 14; i++) begin
      bus.hsync_in = (i < 10) ? 1'b0 : 1'b1;
      tick();
      chk("blank_rden", {31'd0, bus.fb_rd_en}, 32'd0);
      chk_rgb("blank_rgb", 8'h00);
      chk("blank_hs", {31'd0, bus.hsync_out}, (i >= 2 && i <= 11) ? 32'd0 : 32'd1);
    end
    bus.hsync_in = 1'b1;
    tick(); tick();

    // Swap request mid-frame waits for vblank
    drive(0, 300, 1'b0);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick(); tick();
    chk("swap_wait_fbuf", {31'd0, bus.front_buf}, 32'd0);
    chk("swap_wait_ack", {31'd0, bus.swap_ack}, 32'd0);
    bus.calc = 1'b1;
    tick();
    chk("swap_ack_pulse", {31'd0, bus.swap_ack}, 32'd1);
    chk("swap_fbuf", {31'd0, bus.front_buf}, 32'd1);
    tick();
    chk("swap_ack_single", {31'd0, bus.swap_ack}, 32'd0);
    chk("fcnt_1", {16'd0, bus.frame_count}, 32'd1);
    bus.calc = 1'b0;
    drive(0, 0, 1'b1);
    tick();
    chk("next_frame_addr", {16'd0, bus.fb_addr}, 32'h8000);
    drive(0, 0, 1'b0);

    // swap_req held high across three frames gives one swap
    bus.swap_req = 1'b1;
    ack_count = 0;
    for (int f = 0; f < 3; f++) begin
      tick(); tick();
      bus.calc = 1'b1;
      tick();
      ack_count += int'(bus.swap_ack);
      tick();
      ack_count += int'(bus.swap_ack);
      bus.calc = 1'b0;
    end
    chk("held_ack_count", ack_count, 32'd1);
    chk("held_fbuf", {31'd0, bus.front_buf}, 32'd0);
    chk("fcnt_4", {16'd0, bus.frame_count}, 32'd4);

    // Request edge coincident with calc rise
    bus.swap_req = 1'b0;
    tick(); tick();
    bus.swap_req = 1'b1;
    bus.calc = 1'b1;
    tick();
    chk("coinc_ack", {31'd0, bus.swap_ack}, 32'd1);
    chk("coinc_fbuf", {31'd0, bus.front_buf}, 32'd1);
    chk("fcnt_5", {16'd0, bus.frame_count}, 32'd5);
    bus.calc = 1'b0;
    bus.swap_req = 1'b0;
    tick();

    // Reset while pending aborts the swap; syncs read 1 for 3 cycles after release
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.hsync_in = 1'b0;
    reset = 1'b1;
    tick(); tick();
    chk("rst2_fbuf", {31'd0, bus.front_buf}, 32'd0);
    chk("rst2_fcnt", {16'd0, bus.frame_count}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_hs_1", {31'd0, bus.hsync_out}, 32'd1);
    tick();
    chk("rel_hs_2", {31'd0, bus.hsync_out}, 32'd1);
    tick();
    chk("rel_hs_3", {31'd0, bus.hsync_out}, 32'd0);
    bus.hsync_in = 1'b1;
    bus.calc = 1'b1;
    tick();
    chk("abort_ack", {31'd0, bus.swap_ack}, 32'd0);
    chk("abort_fbuf", {31'd0, bus.front_buf}, 32'd0);
    chk("abort_fcnt", {16'd0, bus.frame_count}, 32'd1);
    bus.calc = 1'b0;
    tick();

    // calc rising while reset is held is not counted
    reset = 1'b1;
    bus.calc = 1'b1;
    tick();
    chk("calc_in_rst_fcnt", {16'd0, bus.frame_count}, 32'd0);
    bus.calc = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    chk("fcnt_preload", {16'd0, bus.frame_count}, 32'h0000FFFF);
    bus.calc = 1'b1;
    tick();
    chk("fcnt_wrap", {16'd0, bus.frame_count}, 32'd0);
    bus.calc = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
